// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared video constants and pixel type for the sprite path.
//  Revision    : 1.0  initial release
// ============================================================================
package video_pkg;

    localparam int LINE_W = 256;                 // visible pixels per line
    localparam int PIX_W  = 8;                   // pixel width
    localparam int HC_W   = 9;                   // timing-block counter width
    localparam int ADDR_W = $clog2(LINE_W);      // bank entry address width

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

    // [3:0] colour index, upper bits palette/priority
    typedef logic [PIX_W-1:0] pixel_t;

    // A pixel is drawable only when its colour index is non-transparent
    function automatic logic is_opaque(input pixel_t p);
        return p[3:0] != TRANSPARENT_IDX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_line_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_buffer_if
//  Description : Timing, sprite-write and mixer-side signals of the sprite
//                line buffer. Optional macro LINEBUF_FLIP_EN adds 'flip'.
//  Revision    : 1.0  initial release
// ============================================================================
interface sprite_line_buffer_if;
    import video_pkg::*;

    // timing block side
    logic              clk_pix;
    logic [HC_W-1:0]   hc;
    logic              hbl;
    logic              vbl;
    logic              hsync;
    logic              vsync;
`ifdef LINEBUF_FLIP_EN
    logic              flip;
`endif

    // sprite renderer side
    logic              wr_en;
    logic [HC_W-1:0]   wr_x;
    pixel_t            wr_data;
    logic              line_start;

    // mixer side
    pixel_t            pix_out;
    logic              hbl_out;
    logic              vbl_out;
    logic              hs_out;
    logic              vs_out;

    modport master (
        output clk_pix, hc, hbl, vbl, hsync, vsync,
`ifdef LINEBUF_FLIP_EN
        output flip,
`endif
        output wr_en, wr_x, wr_data,
        input  line_start, pix_out, hbl_out, vbl_out, hs_out, vs_out
    );

    modport slave (
        input  clk_pix, hc, hbl, vbl, hsync, vsync,
`ifdef LINEBUF_FLIP_EN
        input  flip,
`endif
        input  wr_en, wr_x, wr_data,
        output line_start, pix_out, hbl_out, vbl_out, hs_out, vs_out
    );

endinterface
`default_nettype wire

// File: rtl/line_bank.sv
`default_nettype none
// ============================================================================
//  Module      : line_bank
//  Description : One sprite line bank: data storage plus per-entry valid
//                bits, first-written-wins write port and read-and-clear port.
//                rd_data reads as 0 for an empty entry.
//  Revision    : 1.0  initial release
// ============================================================================
module line_bank
    import video_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  wire pixel_t            wr_data,
    input  wire logic              rd_clr,
    input  wire logic [ADDR_W-1:0] rd_addr,
    output pixel_t                 rd_data
);

    pixel_t            r_mem [LINE_W];
    logic [LINE_W-1:0] r_valid;
    logic              w_wr_accept;

    // Transparent pixels and writes to an already-claimed entry are dropped
    assign w_wr_accept = wr_en && is_opaque(wr_data) && !r_valid[wr_addr];

    // Pixel storage; contents are qualified by the valid bits so need no reset
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Valid bits: set on accepted write, cleared when scanned out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else begin
            if (rd_clr) begin
                r_valid[rd_addr] <= 1'b0;
            end
            if (w_wr_accept) begin
                r_valid[wr_addr] <= 1'b1;
            end
        end
    end

    assign rd_data = r_valid[rd_addr] ? r_mem[rd_addr] : '0;

endmodule
`default_nettype wire

// File: rtl/sprite_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_buffer
//  Description : Double-buffered sprite line buffer. The renderer fills the
//                write bank while the read bank is scanned out by hc and
//                erased behind the beam; banks swap on the hblank rising edge.
//                Timing signals are delayed one pixel to align with pix_out.
//                Optional macro LINEBUF_FLIP_EN: horizontal flip of the read
//                address via bus.flip.
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_line_buffer
    import video_pkg::*;
(
    input wire logic            clk,
    input wire logic            reset_n,
    sprite_line_buffer_if.slave bus
);

    localparam logic [HC_W-1:0]   C_LINE_W_HC = HC_W'(LINE_W);
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(LINE_W - 1);

    logic              r_bank_sel;     // write bank index; read bank is the other
    logic              r_hbl_d;
    pixel_t            r_pix_out;
    logic              r_hbl_out;
    logic              r_vbl_out;
    logic              r_hs_out;
    logic              r_vs_out;

    logic              w_swap;
    logic              w_wr_ok;
    logic              w_rd_active;
    logic [ADDR_W-1:0] w_hc_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [1:0]        w_bank_wr_en;
    logic [1:0]        w_bank_rd_clr;
    pixel_t            w_bank_rd_data [2];
    pixel_t            w_rd_data;
    logic              w_unused;

    assign w_swap      = bus.clk_pix && bus.hbl && !r_hbl_d;
    assign w_wr_ok     = bus.wr_en && (bus.wr_x < C_LINE_W_HC);
    assign w_rd_active = bus.clk_pix && !bus.hbl;
    assign w_hc_addr   = bus.hc[ADDR_W-1:0];
    assign w_unused    = bus.hc[HC_W-1];

`ifdef LINEBUF_FLIP_EN
    assign w_rd_addr = bus.flip ? (C_LAST_ADDR - w_hc_addr) : w_hc_addr;
`else
    assign w_rd_addr = w_hc_addr;
`endif

    // Writes follow bank_sel, reads/erases use the opposite bank
    assign w_bank_wr_en[0]  = w_wr_ok && !r_bank_sel;
    assign w_bank_wr_en[1]  = w_wr_ok &&  r_bank_sel;
    assign w_bank_rd_clr[0] = w_rd_active &&  r_bank_sel;
    assign w_bank_rd_clr[1] = w_rd_active && !r_bank_sel;
    assign w_rd_data        = r_bank_sel ? w_bank_rd_data[0] : w_bank_rd_data[1];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        line_bank u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (w_bank_wr_en[g]),
            .wr_addr (bus.wr_x[ADDR_W-1:0]),
            .wr_data (bus.wr_data),
            .rd_clr  (w_bank_rd_clr[g]),
            .rd_addr (w_rd_addr),
            .rd_data (w_bank_rd_data[g])
        );
    end

    // hblank edge detector and bank role toggle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bank_sel <= 1'b0;
            r_hbl_d    <= 1'b0;
        end else if (bus.clk_pix) begin
            r_hbl_d <= bus.hbl;
            if (w_swap) begin
                r_bank_sel <= ~r_bank_sel;
            end
        end
    end

    // Pixel output and timing delay line, advancing once per pixel tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_out <= '0;
            r_hbl_out <= 1'b0;
            r_vbl_out <= 1'b0;
            r_hs_out  <= 1'b0;
            r_vs_out  <= 1'b0;
        end else if (bus.clk_pix) begin
            r_pix_out <= bus.hbl ? '0 : w_rd_data;
            r_hbl_out <= bus.hbl;
            r_vbl_out <= bus.vbl;
            r_hs_out  <= bus.hsync;
            r_vs_out  <= bus.vsync;
        end
    end

    // Swap pulse is combinational so a write in that clk sees line_start
    assign bus.line_start = w_swap && reset_n;
    assign bus.pix_out    = r_pix_out;
    assign bus.hbl_out    = r_hbl_out;
    assign bus.vbl_out    = r_vbl_out;
    assign bus.hs_out     = r_hs_out;
    assign bus.vs_out     = r_vs_out;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_line_buffer
//  Description : Directed self-checking bench for sprite_line_buffer.
//                Covers LINEBUF_FLIP_EN when that macro is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_line_buffer;
    import video_pkg::*;

    localparam int HBL_TICKS = 16;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    int     errors = 0;
    int     checks = 0;
    pixel_t exp_pix [LINE_W];
    bit     flip_mode = 1'b0;
    bit     prev_hb = 1'b0;

    always #5 clk = ~clk;

    sprite_line_buffer_if bus ();

    sprite_line_buffer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < LINE_W; i++) exp_pix[i] = '0;
    endtask

    // One pixel tick: starts and ends at a negedge, clk_pix high for one clk
    task automatic tick(input int h, input bit hb, input bit vb, input bit hs, input bit vs,
                        input bit wr, input int wx, input pixel_t wd, input pixel_t expv);
        bus.hc      = HC_W'(h);
        bus.hbl     = hb;
        bus.vbl     = vb;
        bus.hsync   = hs;
        bus.vsync   = vs;
        bus.clk_pix = 1'b1;
        bus.wr_en   = wr;
        bus.wr_x    = HC_W'(wx);
        bus.wr_data = wd;
        #1;
        check("line_start", 32'(bus.line_start), 32'(hb && !prev_hb));
        prev_hb = hb;
        @(negedge clk);
        bus.clk_pix = 1'b0;
        bus.wr_en   = 1'b0;
        check("pix_out", 32'(bus.pix_out), 32'(expv));
        check("hbl_out", 32'(bus.hbl_out), 32'(hb));
        check("vbl_out", 32'(bus.vbl_out), 32'(vb));
        check("hs_out",  32'(bus.hs_out),  32'(hs));
        check("vs_out",  32'(bus.vs_out),  32'(vs));
        @(negedge clk);
        check("pix_hold", 32'(bus.pix_out), 32'(expv));
    endtask

    // Full line: active pixels checked against exp_pix, then hblank with swap
    task automatic run_line(input bit vb, input bit sw, input int sx, input pixel_t sd);
        for (int h = 0; h < LINE_W; h++) begin
            tick(h, 1'b0, vb, 1'b0, vb, 1'b0, 0, '0,
                 flip_mode ? exp_pix[LINE_W-1-h] : exp_pix[h]);
        end
        for (int h = LINE_W; h < LINE_W + HBL_TICKS; h++) begin
            tick(h, 1'b1, vb, (h >= LINE_W + 4) && (h < LINE_W + 8), vb,
                 sw && (h == LINE_W), sx, sd, '0);
        end
    endtask

    task automatic write_px(input int x, input pixel_t d);
        bus.wr_en   = 1'b1;
        bus.wr_x    = HC_W'(x);
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        bus.clk_pix = 1'b0;
        bus.hc      = '0;
        bus.hbl     = 1'b0;
        bus.vbl     = 1'b0;
        bus.hsync   = 1'b0;
        bus.vsync   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_x    = '0;
        bus.wr_data = '0;
`ifdef LINEBUF_FLIP_EN
        bus.flip    = 1'b0;
`endif
        clear_exp();

        // Reset state
        @(negedge clk);
        check("rst_pix",   32'(bus.pix_out),    32'h0);
        check("rst_ls",    32'(bus.line_start), 32'h0);
        check("rst_hbl",   32'(bus.hbl_out),    32'h0);
        check("rst_vbl",   32'(bus.vbl_out),    32'h0);
        check("rst_hs",    32'(bus.hs_out),     32'h0);
        check("rst_vs",    32'(bus.vs_out),     32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Empty frame: everything transparent, syncs delayed one tick
        run_line(1'b0, 1'b0, 0, '0);
        run_line(1'b0, 1'b0, 0, '0);
        run_line(1'b1, 1'b0, 0, '0);

        // Single pixel, shown on next line, erased after display
        write_px(10, 8'h35);
        run_line(1'b0, 1'b0, 0, '0);
        exp_pix[10] = 8'h35;
        run_line(1'b0, 1'b0, 0, '0);
        clear_exp();
        run_line(1'b0, 1'b0, 0, '0);

        // First write wins; transparent and off-screen writes dropped
        write_px(20, 8'h41);
        write_px(20, 8'h72);
        write_px(30, 8'h50);
        write_px(300, 8'h13);
        run_line(1'b0, 1'b0, 0, '0);
        exp_pix[20] = 8'h41;
        run_line(1'b0, 1'b0, 0, '0);
        clear_exp();

        // Write in the swap clk lands in the pre-swap write bank
        run_line(1'b0, 1'b1, 5, 8'h22);
        exp_pix[5] = 8'h22;
        run_line(1'b0, 1'b0, 0, '0);
        clear_exp();
        run_line(1'b0, 1'b0, 0, '0);

`ifdef LINEBUF_FLIP_EN
        // Flipped scan: x=0 appears at hc=255
        bus.flip  = 1'b1;
        flip_mode = 1'b1;
        write_px(0, 8'h19);
        run_line(1'b0, 1'b0, 0, '0);
        exp_pix[0] = 8'h19;
        run_line(1'b0, 1'b0, 0, '0);
        clear_exp();
        bus.flip  = 1'b0;
        flip_mode = 1'b0;
`endif

        // Reset mid-line wipes both banks
        write_px(7, 8'h3C);
        run_line(1'b0, 1'b0, 0, '0);
        for (int h = 0; h < 5; h++) begin
            tick(h, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, '0);
        end
        bus.hbl   = 1'b1;
        bus.hsync = 1'b1;
        @(negedge clk);
        bus.clk_pix = 1'b1;
        #1;
        check("midrst_prev_pix", 32'(bus.pix_out), 32'h0);
        reset_n = 1'b0;
        #1;
        check("midrst_pix", 32'(bus.pix_out),    32'h0);
        check("midrst_ls",  32'(bus.line_start), 32'h0);
        check("midrst_hs",  32'(bus.hs_out),     32'h0);
        bus.clk_pix = 1'b0;
        bus.hbl     = 1'b0;
        bus.hsync   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        prev_hb = 1'b0;
        @(negedge clk);
        run_line(1'b0, 1'b0, 0, '0);
        run_line(1'b0, 1'b0, 0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
